mmm_arbiter: RTL and testbench

- Shares one bit-serial Montgomery modular multiplier (MMM) datapath between two requesters, e.g. the exponentiation sequencer and a pre-/post-mapping unit.
- Arbitrates round-robin between them and drives the MMM control sequence: clear/load, iterate for a fixed step count, capture the result.
- Returns the product with a one-cycle done pulse to the winning requester.
- Sits between the RSA control units and the single shared MMM instance.

---
 rtl/mmm_arb_pkg.sv | 17 +
 rtl/mmm_step_counter.sv | 26 ++
 rtl/mmm_arbiter.sv | 146 ++++++++++++++
 tb/tb_mmm_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mmm_arb_pkg.sv
// Shared types and constants for the MMM arbiter and its step counter.
package mmm_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_RUN     = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam int STEPS_DEFAULT = 10;

    localparam logic OWNER_0 = 1'b0;
    localparam logic OWNER_1 = 1'b1;

endpackage

// File: rtl/mmm_step_counter.sv
// Iteration counter with clear, increment, global enable and terminal-count flag.
module mmm_step_counter #(
    parameter int STEPS = 10,
    localparam int CW = $clog2(STEPS + 1)
) (
    input  logic          clk,
    input  logic          rstb,
    input  logic          ena,
    input  logic          clr,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          tc
);

    assign tc = (count == CW'(STEPS));

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            count <= '0;
        end else if (ena) begin
            if (clr)      count <= '0;
            else if (inc) count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/mmm_arbiter.sv
// Round-robin arbiter sharing one bit-serial MMM between two requesters.
// Optional macro MMM_ARBITER_ABORT_EN: owner dropping req in LOAD/RUN aborts to IDLE.
module mmm_arbiter import mmm_arb_pkg::*; #(
    parameter int WIDTH = 8,
    parameter int STEPS = STEPS_DEFAULT,
    localparam int CW = $clog2(STEPS + 1)
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             ena,
    input  logic             req0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic             req1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             mmm_rstb,
    output logic             mmm_ld_a,
    output logic [WIDTH-1:0] mmm_a,
    output logic [WIDTH-1:0] mmm_b,
    input  logic [WIDTH-1:0] mmm_res,
    output state_t           dbg_state,
    output logic [CW-1:0]    dbg_count
);

    // Handshake: reqN is a level held until doneN; doneN is a one-cycle pulse
    // with result valid in the same cycle; reqN must drop the cycle after.

    state_t state_q, state_d;
    logic   owner_q, owner_d;
    logic   prio_q, prio_d;     // requester favoured on a tie; becomes the non-owner after DONE
    logic   cnt_clr, cnt_inc, cnt_tc, capture, active;
    logic [WIDTH-1:0] result_q;

    mmm_step_counter #(.STEPS(STEPS)) u_step_counter (
        .clk   (clk),
        .rstb  (rstb),
        .ena   (ena),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .count (dbg_count),
        .tc    (cnt_tc)
    );

`ifdef MMM_ARBITER_ABORT_EN
    logic req_own;
    assign req_own = (owner_q == OWNER_1) ? req1 : req0;
`endif

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q  <= ST_IDLE;
            owner_q  <= OWNER_0;
            prio_q   <= OWNER_0;
            result_q <= '0;
        end else if (ena) begin
            state_q <= state_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
            if (capture) result_q <= mmm_res;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        prio_d  = prio_q;
        cnt_clr = 1'b0;
        cnt_inc = 1'b0;
        capture = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    if (req0 && req1) owner_d = prio_q;
                    else              owner_d = req1 ? OWNER_1 : OWNER_0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                cnt_clr = 1'b1;
                state_d = ST_RUN;
`ifdef MMM_ARBITER_ABORT_EN
                if (!req_own) state_d = ST_IDLE;
`endif
            end
            ST_RUN: begin
                cnt_inc = 1'b1;
                if (cnt_tc) state_d = ST_CAPTURE;
`ifdef MMM_ARBITER_ABORT_EN
                if (!req_own) state_d = ST_IDLE;
`endif
            end
            ST_CAPTURE: begin
                capture = 1'b1;
                cnt_clr = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                prio_d  = ~owner_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decode only registered state; unused encodings look like IDLE.
    always_comb begin
        active   = 1'b0;
        mmm_rstb = 1'b0;
        mmm_ld_a = 1'b0;
        done0    = 1'b0;
        done1    = 1'b0;
        case (state_q)
            ST_LOAD: begin
                active   = 1'b1;
                mmm_ld_a = 1'b1;
            end
            ST_RUN, ST_CAPTURE: begin
                active   = 1'b1;
                mmm_rstb = 1'b1;
            end
            ST_DONE: begin
                active   = 1'b1;
                mmm_rstb = 1'b1;
                done0    = (owner_q == OWNER_0);
                done1    = (owner_q == OWNER_1);
            end
            default: active = 1'b0;
        endcase
    end

    assign busy      = active;
    assign gnt0      = active && (owner_q == OWNER_0);
    assign gnt1      = active && (owner_q == OWNER_1);
    assign mmm_a     = !active ? '0 : (owner_q == OWNER_1) ? a1 : a0;
    assign mmm_b     = !active ? '0 : (owner_q == OWNER_1) ? b1 : b0;
    assign result    = result_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mmm_arbiter.sv
// Directed bench for mmm_arbiter: timed checks plus a done/result scoreboard.
module tb_mmm_arbiter;
    import mmm_arb_pkg::*;

    localparam int WIDTH = 8;
    localparam int STEPS = 10;
    localparam int CW    = $clog2(STEPS + 1);

    // clock / reset
    logic clk = 1'b0;
    logic rstb, ena, req0, req1;
    logic [WIDTH-1:0] a0, b0, a1, b1, mmm_res;
    logic gnt0, gnt1, done0, done1, busy, mmm_rstb, mmm_ld_a;
    logic [WIDTH-1:0] result, mmm_a, mmm_b;
    state_t dbg_state;
    logic [CW-1:0] dbg_count;

    always #5 clk = ~clk;

    mmm_arbiter #(.WIDTH(WIDTH), .STEPS(STEPS)) dut (
        .clk(clk), .rstb(rstb), .ena(ena),
        .req0(req0), .a0(a0), .b0(b0),
        .req1(req1), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .result(result), .busy(busy),
        .mmm_rstb(mmm_rstb), .mmm_ld_a(mmm_ld_a),
        .mmm_a(mmm_a), .mmm_b(mmm_b), .mmm_res(mmm_res),
        .dbg_state(dbg_state), .dbg_count(dbg_count)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    logic [WIDTH:0] exp_q[$];   // {requester, result}
    logic [WIDTH:0] mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // driver tasks
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic to_cycle(input int c);
        while (cyc < c) tick(1);
    endtask

    task automatic pulse_reset();
        rstb = 1'b0;
        tick(2);
        rstb = 1'b1;
        tick(1);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (gnt0 || gnt1) begin
            n_cmp++;
            if (gnt0 && gnt1) begin
                n_err++;
                $display("FAIL gnt_exclusive: gnt0=%0b gnt1=%0b required not both", gnt0, gnt1);
            end
        end
        if (done0 || done1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_done: done0=%0b done1=%0b result=0x%0h, none expected",
                         done0, done1, result);
            end else begin
                mon_e = exp_q.pop_front();
                if ((done0 && done1) || ({done1, result} !== mon_e)) begin
                    n_err++;
                    $display("FAIL done_result: got req%0d 0x%0h expected req%0d 0x%0h",
                             done1, result, mon_e[WIDTH], mon_e[WIDTH-1:0]);
                end
            end
        end
    end

    initial begin
        rstb = 1'b0; ena = 1'b1; req0 = 1'b0; req1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0; mmm_res = '0;
        tick(2);
        check("rst_busy", busy, 0);
        check("rst_gnt", {gnt0, gnt1}, 0);
        check("rst_mmm_ctl", {mmm_rstb, mmm_ld_a}, 0);
        check("rst_mmm_ops", {mmm_a, mmm_b}, 0);
        check("rst_result", result, 0);
        rstb = 1'b1;
        tick(1);

        // single request from requester 0
        cyc = 0; a0 = 8'h3C; b0 = 8'h5A; mmm_res = 8'hA5; req0 = 1'b1;
        exp_q.push_back({1'b0, 8'hA5});
        tick(1);
        check("t1_load_gnt", {gnt0, gnt1}, 2'b10);
        check("t1_load_ctl", {mmm_ld_a, mmm_rstb}, 2'b10);
        check("t1_load_ops", {mmm_a, mmm_b}, 16'h3C5A);
        to_cycle(2);
        check("t1_run_ctl", {mmm_ld_a, mmm_rstb}, 2'b01);
        to_cycle(13);
        check("t1_capture_state", 32'(dbg_state), 32'(ST_CAPTURE));
        check("t1_no_early_done", done0, 0);
        to_cycle(14);
        check("t1_done0", done0, 1);
        check("t1_done_ops", {mmm_a, mmm_b}, 16'h3C5A);
        req0 = 1'b0;
        to_cycle(15);
        check("t1_idle_busy", busy, 0);
        check("t1_result_hold", result, 8'hA5);

        // simultaneous requests after reset
        pulse_reset();
        cyc = 0; a0 = 8'h11; b0 = 8'h22; a1 = 8'h33; b1 = 8'h44;
        mmm_res = 8'h5C; req0 = 1'b1; req1 = 1'b1;
        exp_q.push_back({1'b0, 8'h5C});
        exp_q.push_back({1'b1, 8'hC3});
        tick(1);
        check("t2_first_gnt", {gnt0, gnt1}, 2'b10);
        to_cycle(14);
        check("t2_done0", {done0, done1}, 2'b10);
        req0 = 1'b0; mmm_res = 8'hC3;
        to_cycle(15);
        check("t2_idle_gap", busy, 0);
        to_cycle(16);
        check("t2_second_gnt", {gnt0, gnt1}, 2'b01);
        check("t2_second_ops", {mmm_a, mmm_b}, 16'h3344);
        to_cycle(29);
        check("t2_done1", {done0, done1}, 2'b01);
        req1 = 1'b0;
        to_cycle(30);

        // round robin after requester 1 served; req0 held past its done
        cyc = 0; a0 = 8'h55; b0 = 8'h66; a1 = 8'h77; b1 = 8'h88;
        mmm_res = 8'h69; req0 = 1'b1; req1 = 1'b1;
        exp_q.push_back({1'b0, 8'h69});
        exp_q.push_back({1'b1, 8'h96});
        tick(1);
        check("t3_rr_gnt0", {gnt0, gnt1}, 2'b10);
        to_cycle(14);
        check("t3_done0", done0, 1);
        mmm_res = 8'h96;
        to_cycle(16);
        check("t3_rr_gnt1", {gnt0, gnt1}, 2'b01);
        check("t3_ops1", {mmm_a, mmm_b}, 16'h7788);
        req0 = 1'b0;
        to_cycle(29);
        check("t3_done1", done1, 1);
        req1 = 1'b0;
        to_cycle(30);

        // requester 0 drops req in RUN
        cyc = 0; a0 = 8'h9A; b0 = 8'hBC; mmm_res = 8'h7E; req0 = 1'b1;
`ifndef MMM_ARBITER_ABORT_EN
        exp_q.push_back({1'b0, 8'h7E});
`endif
        to_cycle(6);
        req0 = 1'b0;
`ifdef MMM_ARBITER_ABORT_EN
        to_cycle(7);
        check("t4_abort_idle", {busy, gnt0}, 2'b00);
        to_cycle(16);
        check("t4_abort_result", result, 8'h96);
`else
        to_cycle(7);
        check("t4_keeps_running", {busy, gnt0}, 2'b11);
        to_cycle(14);
        check("t4_done0", done0, 1);
        check("t4_result", result, 8'h7E);
        to_cycle(15);
        check("t4_idle", busy, 0);
`endif

        // enable held low for five cycles in RUN
        cyc = 0; a0 = 8'h0F; b0 = 8'hF0; mmm_res = 8'hB7; req0 = 1'b1;
        exp_q.push_back({1'b0, 8'hB7});
        to_cycle(5);
        ena = 1'b0;
        to_cycle(9);
        check("t5_frozen_count", dbg_count, 3);
        check("t5_frozen_outs", {busy, gnt0, mmm_rstb}, 3'b111);
        to_cycle(10);
        ena = 1'b1;
        to_cycle(18);
        check("t5_capture_late", 32'(dbg_state), 32'(ST_CAPTURE));
        to_cycle(19);
        check("t5_done0", done0, 1);
        check("t5_result", result, 8'hB7);
        req0 = 1'b0;
        to_cycle(20);

        // reset in the middle of an operation
        cyc = 0; a0 = 8'h21; b0 = 8'h43; mmm_res = 8'h42; req0 = 1'b1;
        to_cycle(8);
        rstb = 1'b0; req0 = 1'b0;
        #1;
        check("t6_async_gnt", {gnt0, busy, mmm_ld_a}, 0);
        check("t6_async_result", result, 0);
        check("t6_async_ops", mmm_a, 0);
        tick(1);
        rstb = 1'b1;
        tick(1);
        cyc = 0; a1 = 8'hE1; b1 = 8'h5F; mmm_res = 8'h1D; req1 = 1'b1;
        exp_q.push_back({1'b1, 8'h1D});
        tick(1);
        check("t6_gnt1", {gnt0, gnt1}, 2'b01);
        check("t6_ops1", {mmm_a, mmm_b}, 16'hE15F);
        to_cycle(14);
        check("t6_done1", done1, 1);
        check("t6_result", result, 8'h1D);
        req1 = 1'b0;
        to_cycle(16);
        check("t6_idle", busy, 0);

        // final report
        tick(2);
        check("exp_q_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
